// File: rtl/ultratank_dl_pkg.sv
// ultratank_dl_pkg
// Shared types and address-field constants for the Ultra Tank ROM download
// sequencer.
//   dl_state_t : sequencer FSM states
//   dl_entry_t : one queued download byte {region, offset, data}
package ultratank_dl_pkg;

    localparam int ADDR_W     = 25;  // ioctl byte address width
    localparam int OFFSET_W   = 12;  // offset within a ROM region
    localparam int REGION_LSB = 12;  // region index sits at ioctl_addr[15:12]
    localparam int REGION_W   = 4;
    localparam int UPPER_LSB  = 16;  // ioctl_addr[24:16] must be zero

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } dl_state_t;

    typedef struct packed {
        logic [REGION_W-1:0] region;
        logic [OFFSET_W-1:0] offset;
        logic [7:0]          data;
    } dl_entry_t;

endpackage

// File: rtl/ultratank_dl_fifo.sv
// ultratank_dl_fifo
// Small synchronous first-word-fall-through FIFO.
// Ports:
//   clk_sys, reset : clock and synchronous active-high reset (flushes)
//   push, din      : write an entry (ignored when full)
//   pop, dout      : dout shows the head entry; pop removes it (ignored when empty)
//   full, empty    : occupancy flags
//   count          : registered occupancy, 0..DEPTH
module ultratank_dl_fifo
    import ultratank_dl_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = dl_entry_t
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     din,
    input  logic                       pop,
    output entry_t                     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ultratank_dl_sequencer.sv
// ultratank_dl_sequencer
// Queues HPS download bytes and writes them into the Ultra Tank shared
// ROM/RAM port in cycles the game core leaves free. Holds the game in reset
// during a download and for HOLD_CYCLES after the queue drains.
// Ports:
//   clk_sys, reset          : 12 MHz clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout : HPS download stream
//   ioctl_wait              : registered back-pressure to the HPS
//   mem_busy                : game core owns the shared port this cycle
//   wr_en/wr_addr/wr_data/rom_sel : registered shared-port write
//   game_reset              : reset to the game core (high outside IDLE)
//   dl_error                : sticky overflow / bad-address flag
//   dbg_state               : current FSM state (dl_state_t encoding)
// Optional feature macro ULTRATANK_DL_CHECKSUM_EN adds:
//   dl_sum                  : mod-256 sum of bytes written this download
//   dl_sum_valid            : IDLE after an error-free download
//
// Handshake: a byte is accepted on any cycle with ioctl_wr & ioctl_download,
// a good address and a non-full queue; otherwise it is dropped and dl_error
// set. ioctl_wait is advisory and lags the queue level by one cycle, leaving
// one slot for a strobe already in flight.
module ultratank_dl_sequencer
    import ultratank_dl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int REGIONS     = 8,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    input  logic                mem_busy,
    output logic                wr_en,
    output logic [11:0]         wr_addr,
    output logic [7:0]          wr_data,
    output logic [REGIONS-1:0]  rom_sel,
    output logic                game_reset,
    output logic                dl_error,
    output logic [1:0]          dbg_state
`ifdef ULTRATANK_DL_CHECKSUM_EN
    ,
    output logic [7:0]          dl_sum,
    output logic                dl_sum_valid
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]       HOLD_INIT    = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]       WAIT_LEVEL   = CW'(DEPTH - 1);
    localparam logic [REGION_W:0]   REGION_LIMIT = REGIONS[REGION_W:0];
    localparam logic [REGIONS-1:0]  SEL_ONE      = {{(REGIONS-1){1'b0}}, 1'b1};

    dl_state_t      state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           enter_load;

    logic [REGION_W-1:0] region;
    logic           addr_ok;
    logic           strobe;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           err_set;
    dl_entry_t      push_entry;
    dl_entry_t      pop_entry;

    // Region decode: only the low 64 KiB is mapped, split into 4 KiB regions.
    assign region  = ioctl_addr[REGION_LSB+REGION_W-1:REGION_LSB];
    assign addr_ok = (ioctl_addr[ADDR_W-1:UPPER_LSB] == '0) &&
                     ({1'b0, region} < REGION_LIMIT);

    assign strobe    = ioctl_wr & ioctl_download;
    assign fifo_push = strobe & addr_ok & ~fifo_full;
    assign err_set   = strobe & (~addr_ok | fifo_full);
    assign fifo_pop  = ~fifo_empty & ~mem_busy;

    assign push_entry.region = region;
    assign push_entry.offset = ioctl_addr[OFFSET_W-1:0];
    assign push_entry.data   = ioctl_dout;

    ultratank_dl_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (dl_entry_t)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (fifo_push),
        .din     (push_entry),
        .pop     (fifo_pop),
        .dout    (pop_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= HOLD;
            hold_q  <= HOLD_INIT;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // FSM next state. A new download always wins over the hold countdown.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        enter_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_download) state_d = DRAIN;
            end
            DRAIN: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                end else if (fifo_empty) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            HOLD: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign game_reset = (state_q != IDLE);
    assign dbg_state  = state_q;

    // Registered write port, back-pressure and error flag. An error in the
    // same cycle as LOAD entry is kept, since it belongs to the new download.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_en      <= 1'b0;
            rom_sel    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            ioctl_wait <= 1'b0;
            dl_error   <= 1'b0;
        end else begin
            wr_en      <= fifo_pop;
            rom_sel    <= fifo_pop ? (SEL_ONE << pop_entry.region) : '0;
            if (fifo_pop) begin
                wr_addr <= pop_entry.offset;
                wr_data <= pop_entry.data;
            end
            ioctl_wait <= (fifo_count >= WAIT_LEVEL);
            if (err_set)         dl_error <= 1'b1;
            else if (enter_load) dl_error <= 1'b0;
        end
    end

`ifdef ULTRATANK_DL_CHECKSUM_EN
    // dl_done_q marks that a download has run to completion (queue drained),
    // so the sum is not reported as valid straight out of reset.
    logic dl_done_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_sum    <= '0;
            dl_done_q <= 1'b0;
        end else begin
            if (enter_load) begin
                dl_sum    <= '0;
                dl_done_q <= 1'b0;
            end else if (fifo_pop) begin
                dl_sum <= dl_sum + pop_entry.data;
            end
            if (state_q == DRAIN && state_d == HOLD) dl_done_q <= 1'b1;
        end
    end

    assign dl_sum_valid = (state_q == IDLE) && dl_done_q && !dl_error;
`endif

endmodule
